// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the ID-stage immediate generator: format codes and the
// entry layout held in both the skid and output registers.
package imm_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic            sel_err;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Upstream/downstream handshake bundle for the immediate generator stage.
interface imm_gen_stage_if;
    import imm_pkg::*;

    logic            i_valid;
    logic            o_in_ready;
    logic [XLEN-1:0] i_instr;
    logic [XLEN-1:0] i_pc;
    logic [2:0]      i_imm_sel;
    logic            i_flush;
    logic            o_valid;
    logic            i_out_ready;
    logic [XLEN-1:0] o_imm;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_pc;
    logic            o_sel_err;

    modport master (
        output i_valid, i_instr, i_pc, i_imm_sel, i_flush, i_out_ready,
        input  o_in_ready, o_valid, o_imm, o_instr, o_pc, o_sel_err
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_imm_sel, i_flush, i_out_ready,
        output o_in_ready, o_valid, o_imm, o_instr, o_pc, o_sel_err
    );

endinterface

// File: rtl/imm_gen_stage_ext.sv
// Combinational immediate formatter; opcode bits [6:0] never feed any format.
module imm_ext
    import imm_pkg::*;
(
    input  logic [31:7] instr,
    input  logic [2:0]  sel,
    output logic [31:0] imm,
    output logic        sel_err
);

    always_comb begin
        imm     = '0;
        sel_err = 1'b0;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: sel_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// ID/EX immediate stage: formats the immediate on entry, then holds it in an
// output register backed by a one-entry skid so upstream ready is a flop.
module imm_gen_stage #(
    parameter int unsigned XLEN = imm_pkg::XLEN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    imm_gen_stage_if.slave    bus
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("imm_gen_stage supports XLEN=32 only");
    end

    imm_pkg::imm_entry_t new_entry;
    imm_pkg::imm_entry_t out_q, out_d;
    imm_pkg::imm_entry_t skid_q, skid_d;
    logic                out_valid_q, out_valid_d;
    logic                skid_valid_q, skid_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [31:0]         new_imm;
    logic                new_err;
    logic                accept;
    logic                drain;

    imm_ext u_ext (
        .instr   (bus.i_instr[31:7]),
        .sel     (bus.i_imm_sel),
        .imm     (new_imm),
        .sel_err (new_err)
    );

    always_comb begin
        new_entry.instr   = bus.i_instr;
        new_entry.pc      = bus.i_pc;
        new_entry.imm     = new_imm;
        new_entry.sel_err = new_err;
    end

    assign accept = bus.i_valid & in_ready_q;
    assign drain  = out_valid_q & bus.i_out_ready;

    // Output register refills from skid first, so ordering stays strict.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.o_in_ready = in_ready_q;
    assign bus.o_valid    = out_valid_q;
    assign bus.o_imm      = out_q.imm;
    assign bus.o_instr    = out_q.instr;
    assign bus.o_pc       = out_q.pc;
    assign bus.o_sel_err  = out_q.sel_err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: formats, backpressure, skid, flush, reset.
module tb_imm_gen_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    imm_gen_stage_if bus ();

    imm_gen_stage u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] sel);
        bus.i_valid   = 1'b1;
        bus.i_instr   = instr;
        bus.i_pc      = pc;
        bus.i_imm_sel = sel;
        cycle();
        bus.i_valid   = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_valid"},    32'(bus.o_valid), 32'd0);
        check({pfx, "_imm"},      bus.o_imm,   32'h0);
        check({pfx, "_instr"},    bus.o_instr, 32'h0);
        check({pfx, "_pc"},       bus.o_pc,    32'h0);
        check({pfx, "_sel_err"},  32'(bus.o_sel_err), 32'd0);
        check({pfx, "_in_ready"}, 32'(bus.o_in_ready), 32'd1);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_instr     = '0;
        bus.i_pc        = '0;
        bus.i_imm_sel   = '0;
        bus.i_flush     = 1'b0;
        bus.i_out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_reset_state("rst");

        // Formats with EX always ready
        push(32'hFFF00093, 32'h0, 3'b000);
        check("i_valid", 32'(bus.o_valid), 32'd1);
        check("i_imm",   bus.o_imm,   32'hFFFFFFFF);
        check("i_instr", bus.o_instr, 32'hFFF00093);
        push(32'h123452B7, 32'h4, 3'b011);
        check("u_imm",   bus.o_imm,   32'h12345000);
        push(32'hFE20AE23, 32'h8, 3'b001);
        check("s_imm",   bus.o_imm,   32'hFFFFFFFC);
        push(32'h00000863, 32'hC, 3'b010);
        check("b_imm",   bus.o_imm,   32'h00000010);
        push(32'h001000EF, 32'h10, 3'b100);
        check("j_imm",   bus.o_imm,   32'h00000800);
        check("j_pc",    bus.o_pc,    32'h10);
        cycle();
        check("idle_valid", 32'(bus.o_valid), 32'd0);

        // Backpressure: A in output, B in skid
        bus.i_out_ready = 1'b0;
        push(32'h00100093, 32'h100, 3'b000);
        check("bp_a_valid", 32'(bus.o_valid), 32'd1);
        check("bp_a_ready", 32'(bus.o_in_ready), 32'd1);
        push(32'h00200093, 32'h104, 3'b000);
        check("bp_b_ready", 32'(bus.o_in_ready), 32'd0);
        check("stall_pc0",  bus.o_pc, 32'h100);
        cycle();
        check("stall_pc1",  bus.o_pc, 32'h100);
        check("stall_imm1", bus.o_imm, 32'h1);
        cycle();
        check("stall_pc2",  bus.o_pc, 32'h100);
        bus.i_out_ready = 1'b1;
        cycle();
        check("drain_b_pc",    bus.o_pc, 32'h104);
        check("drain_b_imm",   bus.o_imm, 32'h2);
        check("drain_b_valid", 32'(bus.o_valid), 32'd1);
        check("drain_ready",   32'(bus.o_in_ready), 32'd1);
        cycle();
        check("drain_empty",   32'(bus.o_valid), 32'd0);

        // Flush with skid full and a concurrent valid input
        bus.i_out_ready = 1'b0;
        push(32'h00300093, 32'h1F0, 3'b000);
        push(32'h00400093, 32'h1F4, 3'b000);
        check("fl_skid_full", 32'(bus.o_in_ready), 32'd0);
        bus.i_flush = 1'b1;
        push(32'h00500093, 32'h200, 3'b000);
        bus.i_flush = 1'b0;
        check("fl_valid", 32'(bus.o_valid), 32'd0);
        check("fl_ready", 32'(bus.o_in_ready), 32'd1);
        bus.i_out_ready = 1'b1;
        cycle();
        check("fl_post_valid", 32'(bus.o_valid), 32'd0);
        // Flush also overrides an accept while ready is high
        bus.i_flush = 1'b1;
        push(32'h00600093, 32'h208, 3'b000);
        bus.i_flush = 1'b0;
        check("fl_acc_valid", 32'(bus.o_valid), 32'd0);
        cycle();
        check("fl_acc_valid2", 32'(bus.o_valid), 32'd0);

        // Reserved select
        push(32'hFFFFFFFF, 32'h300, 3'b101);
        check("rsv_valid", 32'(bus.o_valid), 32'd1);
        check("rsv_imm",   bus.o_imm, 32'h0);
        check("rsv_err",   32'(bus.o_sel_err), 32'd1);
        push(32'hFFF00093, 32'h304, 3'b000);
        check("rsv_next_err", 32'(bus.o_sel_err), 32'd0);
        check("rsv_next_imm", bus.o_imm, 32'hFFFFFFFF);
        bus.i_imm_sel = 3'bxxx;
        cycle();
        check("x_sel_err", 32'(bus.o_sel_err), 32'd0);
        check("x_sel_imm", bus.o_imm, 32'hFFFFFFFF);

        // Reset mid-stream with skid full
        bus.i_out_ready = 1'b0;
        push(32'h00700093, 32'h380, 3'b000);
        push(32'h00800093, 32'h384, 3'b000);
        check("mr_skid_full", 32'(bus.o_in_ready), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_state("mr");
        bus.i_out_ready = 1'b1;
        push(32'h123452B7, 32'h400, 3'b011);
        check("mr_first_valid", 32'(bus.o_valid), 32'd1);
        check("mr_first_pc",    bus.o_pc, 32'h400);
        check("mr_first_imm",   bus.o_imm, 32'h12345000);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Consumer end of the ID-stage `imm_sel` interface.
- Takes a fetched instruction word, its PC and the 3-bit `imm_sel` code from the ID control unit.
- Builds the sign-extended 32-bit immediate for that format and registers it, with the instruction and PC, into the ID/EX boundary.
- Uses a valid/ready handshake with a one-entry skid buffer, so upstream `i_ready` is a pure register output.

Parameters:
- XLEN, 32, datapath width; only 32 is supported, other values are an elaboration error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  upstream holds a valid instruction
- o_in_ready  out  1  stage can accept this cycle (registered)
- i_instr  in  32  instruction word
- i_pc  in  32  instruction PC
- i_imm_sel  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101-111 reserved
- i_flush  in  1  kill all held entries (branch redirect)
- o_valid  out  1  output entry valid
- i_out_ready  in  1  EX accepts output this cycle
- o_imm  out  32  generated immediate
- o_instr  out  32  registered instruction
- o_pc  out  32  registered PC
- o_sel_err  out  1  entry carried a reserved imm_sel

Behaviour:
- Interface: one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- Reset values: o_valid=0, o_imm=0, o_instr=0, o_pc=0, o_sel_err=0, skid entry empty, o_in_ready=1.
- Immediate formats (bit ranges are i_instr):
  - I: sext(i_instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],1'b0}).
  - U: {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],1'b0}).
  - Reserved codes: immediate = 0 and o_sel_err = 1.
- Accept: a transfer occurs when i_valid and o_in_ready are both high. Latency is 1 cycle: a transfer at edge N appears on the outputs after edge N.
- Output register: loads when it is empty or is being drained (o_valid & i_out_ready). Source priority is the skid entry first, then the new input.
- Skid: when input is accepted while the output is valid and not drained, the entry goes to the skid register. o_in_ready goes low the next cycle. o_in_ready = !skid_valid.
- Ordering: strictly in-order; the skid entry always leaves before any newer entry.
- Stall: while o_valid & !i_out_ready, o_imm, o_instr, o_pc and o_sel_err hold stable.
- Simultaneous drain and accept with skid empty: the new entry goes directly to the output register, with no bubble.
- Drain with skid full: the skid entry moves to the output register. o_in_ready returns to 1 the following cycle.
- Flush:
  - Next cycle: o_valid=0, skid empty, o_in_ready=1.
  - Flush overrides any same-cycle accept or drain; the accepted instruction is discarded.
  - The data registers may keep stale values.
- Reset mid-operation: identical to flush, plus data registers are cleared to 0. Reset has priority over flush.
- Input data is ignored when i_valid=0. X on i_imm_sel while i_valid=0 must not propagate into held state.

Decomposition:
- Package `imm_pkg`:
  - `imm_sel_e` enum constants IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_U=3'b011, IMM_J=3'b100.
  - XLEN default.
  - Packed struct `imm_entry_t` {instr, pc, imm, sel_err}, used for both the skid and output registers.
- Sub-module `imm_ext`: purely combinational formatter (instr, sel -> imm, sel_err). It is instantiated once, on the input side, so the stored entries already hold the final immediate.

Test Plan:
- I and U formats, o_out_ready=1 held:
  - i_instr=0xFFF00093, sel=000 -> next cycle o_valid=1, o_imm=0xFFFFFFFF.
  - Then 0x123452B7, sel=011 -> o_imm=0x12345000.
- S, B and J formats:
  - 0xFE20AE23, sel=001 -> o_imm=0xFFFFFFFC.
  - 0x00000863, sel=010 -> o_imm=0x00000010.
  - 0x001000EF, sel=100 -> o_imm=0x00000800.
- Backpressure:
  - Stimulus: i_out_ready=0; push A (pc=0x100) then B (pc=0x104).
  - Required: o_in_ready=0 after B; o_pc holds 0x100 for 3 stall cycles.
  - Then raise i_out_ready: 0x100 then 0x104 out on consecutive cycles, no loss or duplication; o_in_ready=1 one cycle after the skid drains.
- Flush with skid full: assert i_flush with a concurrent valid input (pc=0x200) -> next cycle o_valid=0, o_in_ready=1; 0x200 never appears on the outputs.
- Reserved sel: sel=101, any instr -> o_imm=0, o_sel_err=1. The next valid I-type entry has o_sel_err=0.
- Reset mid-stream:
  - Stimulus: i_rst for 1 cycle while o_valid=1 and the skid is full.
  - Required: all outputs 0 and o_in_ready=1 next cycle.
  - Required after release: the first accepted instruction appears after exactly 1 cycle.
